axi_s_mem: RTL

AXI burst responder backed by an on-chip word-addressed memory. It is the slave-side counterpart of the core's AXI master: it accepts 32-bit INCR/FIXED bursts on independent read and write channels, performs them against an internal array, and returns B and R responses. It sits behind the interconnect as the simulation and FPGA main-memory model for cache line refills and writebacks.

---
 rtl/axi_s_mem.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_s_mem.sv
// axi_s_mem: AXI burst responder backed by an on-chip word-addressed memory.
// Serves 32-bit INCR/FIXED bursts (WRAP and reserved encodings act as INCR) on
// independent read and write channels, returning B and R responses.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock (rising edge), async active-low reset
//   S_AXI_AW*                   write address channel (AWSIZE ignored, 32-bit)
//   S_AXI_W*                    write data channel, byte strobes honoured
//   S_AXI_B*                    write response: OKAY, SLVERR on WLAST/AWLEN mismatch
//   S_AXI_AR*                   read address channel (ARSIZE ignored, 32-bit)
//   S_AXI_R*                    read data channel, registered data
//
// Optional feature macro: AXI_S_RANGE_CHK_EN
//   defined   - beats outside [SLV_ADDR_BASE, SLV_ADDR_BASE+4*MEM_DEPTH) are not
//               stored / read as zero and answered with DECERR
//   undefined - word index wraps modulo MEM_DEPTH
module axi_s_mem #(
    parameter int unsigned         WIDTH_ID      = 1,
    parameter int unsigned         WIDTH_AD      = 32,
    parameter int unsigned         WIDTH_DA      = 32,
    parameter int unsigned         MEM_DEPTH     = 1024,
    parameter logic [WIDTH_AD-1:0] SLV_ADDR_BASE = '0
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [WIDTH_ID-1:0]   S_AXI_AWID,
    input  logic [WIDTH_AD-1:0]   S_AXI_AWADDR,
    input  logic [3:0]            S_AXI_AWLEN,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [WIDTH_DA-1:0]   S_AXI_WDATA,
    input  logic [WIDTH_DA/8-1:0] S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [WIDTH_ID-1:0]   S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [WIDTH_ID-1:0]   S_AXI_ARID,
    input  logic [WIDTH_AD-1:0]   S_AXI_ARADDR,
    input  logic [3:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [WIDTH_ID-1:0]   S_AXI_RID,
    output logic [WIDTH_DA-1:0]   S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned OFF_W = WIDTH_AD - 2;
    localparam int unsigned NB    = WIDTH_DA / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [WIDTH_DA-1:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_t            w_state, w_state_nxt;
    logic [WIDTH_AD-1:0] aw_byte_off;
    logic [OFF_W-1:0]    wr_off;
    logic [3:0]          wr_len;
    logic                wr_fixed;
    logic [4:0]          wr_beats, wr_beats_nxt;
    logic                wr_err;
    logic                wr_oor_c;
    logic                aw_hs, w_hs, b_hs;

    // Offsets below the base wrap to huge values, so one compare covers both ends.
    assign aw_byte_off  = S_AXI_AWADDR - SLV_ADDR_BASE;
    assign aw_hs        = (w_state == W_IDLE) && S_AXI_AWREADY && S_AXI_AWVALID;
    assign w_hs         = (w_state == W_DATA) && S_AXI_WREADY && S_AXI_WVALID;
    assign b_hs         = (w_state == W_RESP) && S_AXI_BVALID && S_AXI_BREADY;
    assign wr_beats_nxt = (wr_beats == 5'h1f) ? wr_beats : wr_beats + 5'd1;

`ifdef AXI_S_RANGE_CHK_EN
    assign wr_oor_c = (wr_off >= OFF_W'(MEM_DEPTH));
`else
    assign wr_oor_c = 1'b0;
`endif

    // Write FSM next state
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && S_AXI_WLAST) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write state, burst context and registered AW/W/B outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            S_AXI_BID     <= '0;
            wr_off        <= '0;
            wr_len        <= '0;
            wr_fixed      <= 1'b0;
            wr_beats      <= '0;
            wr_err        <= 1'b0;
        end else begin
            w_state       <= w_state_nxt;
            S_AXI_AWREADY <= (w_state_nxt == W_IDLE);
            S_AXI_WREADY  <= (w_state_nxt == W_DATA);
            S_AXI_BVALID  <= (w_state_nxt == W_RESP);
            if (aw_hs) begin
                S_AXI_BID <= S_AXI_AWID;
                wr_off    <= aw_byte_off[WIDTH_AD-1:2];
                wr_len    <= S_AXI_AWLEN;
                wr_fixed  <= (S_AXI_AWBURST == BURST_FIXED);
                wr_beats  <= '0;
                wr_err    <= 1'b0;
            end
            if (w_hs) begin
                if (!wr_fixed) wr_off <= wr_off + OFF_W'(1);
                wr_beats <= wr_beats_nxt;
                wr_err   <= wr_err | wr_oor_c;
                if (S_AXI_WLAST) begin
                    if (wr_err || wr_oor_c)
                        S_AXI_BRESP <= RESP_DECERR;
                    else if (wr_beats_nxt == 5'(wr_len) + 5'd1)
                        S_AXI_BRESP <= RESP_OKAY;
                    else
                        S_AXI_BRESP <= RESP_SLVERR;
                end
            end
        end
    end

    // Byte-enabled array write; contents survive reset
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_hs && !wr_oor_c) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (S_AXI_WSTRB[b]) mem[wr_off[IDX_W-1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t            r_state, r_state_nxt;
    logic [WIDTH_AD-1:0] ar_byte_off;
    logic [OFF_W-1:0]    rd_off, rd_fetch_off_c;
    logic [3:0]          rd_len, rd_beat;
    logic                rd_fixed;
    logic                rd_oor_c;
    logic                ar_hs, r_hs, r_load;

    assign ar_byte_off = S_AXI_ARADDR - SLV_ADDR_BASE;
    assign ar_hs       = (r_state == R_IDLE) && S_AXI_ARREADY && S_AXI_ARVALID;
    assign r_hs        = (r_state == R_DATA) && S_AXI_RVALID && S_AXI_RREADY;
    // Output registers reload on AR accept and on every non-final beat taken.
    assign r_load      = ar_hs || (r_hs && !S_AXI_RLAST);
    assign rd_fetch_off_c = ar_hs    ? ar_byte_off[WIDTH_AD-1:2] :
                            rd_fixed ? rd_off : rd_off + OFF_W'(1);

`ifdef AXI_S_RANGE_CHK_EN
    assign rd_oor_c = (rd_fetch_off_c >= OFF_W'(MEM_DEPTH));
`else
    assign rd_oor_c = 1'b0;
`endif

    // Read FSM next state
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && S_AXI_RLAST) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read state and registered AR/R outputs; array read sees pre-write data
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RID     <= '0;
            rd_off        <= '0;
            rd_len        <= '0;
            rd_beat       <= '0;
            rd_fixed      <= 1'b0;
        end else begin
            r_state       <= r_state_nxt;
            S_AXI_ARREADY <= (r_state_nxt == R_IDLE);
            S_AXI_RVALID  <= (r_state_nxt == R_DATA);
            if (r_load) begin
                rd_off      <= rd_fetch_off_c;
                S_AXI_RDATA <= rd_oor_c ? '0 : mem[rd_fetch_off_c[IDX_W-1:0]];
                S_AXI_RRESP <= rd_oor_c ? RESP_DECERR : RESP_OKAY;
            end
            if (ar_hs) begin
                S_AXI_RID   <= S_AXI_ARID;
                rd_len      <= S_AXI_ARLEN;
                rd_fixed    <= (S_AXI_ARBURST == BURST_FIXED);
                rd_beat     <= '0;
                S_AXI_RLAST <= (S_AXI_ARLEN == 4'd0);
            end else if (r_hs) begin
                rd_beat     <= rd_beat + 4'd1;
                S_AXI_RLAST <= (rd_beat + 4'd1 == rd_len);
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWSIZE, S_AXI_ARSIZE, aw_byte_off[1:0], ar_byte_off[1:0]};

endmodule
